if_fetch_unit: RTL and testbench

//   Instruction-fetch stage; drives the 64-bit IF/ID bus {PC+4, instruction} consumed by the IF/ID pipeline register.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/if_fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: IF/ID bus width, NOP encoding,
// fetch-stage state encoding and the default PC increment.
package mips_pkg;

    localparam int          IFID_W         = 64;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEFAULT = 32'd4;

    // Fetch-stage control states.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding at imem_addr = pc
        ST_HOLD  = 2'd1,  // fetched word parked while the hazard unit stalls
        ST_DRAIN = 2'd2   // stale request in flight after a redirect; response is dropped
    } fetch_state_e;

    // Pack {return PC, instruction} into the IF/ID bus layout.
    function automatic logic [IFID_W-1:0] pack_ifid(input logic [31:0] pc_plus,
                                                    input logic [31:0] instr);
        return {pc_plus, instr};
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, runs the req/ack handshake to
// instruction memory, parks a fetched word while the pipeline is stalled,
// and applies redirects and flush bubbles to the registered IF/ID bus.
// Optional performance counters are built when IF_PERF_CNT_EN is defined;
// otherwise perf_fetch_cnt / perf_stall_cnt read as zero.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [63:0] ifid_bus,
    output logic        ifid_valid,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    fetch_state_e state_q, state_d;

    logic [31:0]       pc_q,         pc_d;
    logic [31:0]       drain_addr_q, drain_addr_d;
    logic [31:0]       hold_pc_q,    hold_pc_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic [IFID_W-1:0] ifid_bus_q,   ifid_bus_d;
    logic              ifid_valid_q, ifid_valid_d;

    // A response only counts while a request is actually being driven.
    logic ack_eff;
    assign ack_eff = imem_ack && imem_req;

    // State register.
    // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect outranks stall and the ack data.
    // NOTE: next-state defaults to the current state first, so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    state_d = ack_eff ? ST_FETCH : ST_DRAIN;
                end else if (ack_eff && stall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || !stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (!redirect_valid && ack_eff) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Memory-side outputs; no request while reset is asserted or while holding.
    always_comb begin
        imem_req  = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && !rst;
        imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    end

    // PC, hold buffer, drain address and IF/ID bus next values.
    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        ifid_bus_d   = ifid_bus_q;
        // Under stall the valid flag is frozen with the bus; otherwise a cycle
        // without a delivery must not re-issue the previous instruction.
        ifid_valid_d = stall ? ifid_valid_q : 1'b0;

        if (redirect_valid) begin
            pc_d         = redirect_pc;
            hold_pc_d    = 32'h0;
            hold_instr_d = NOP_INSTR;
            ifid_bus_d   = '0;
            ifid_valid_d = 1'b0;
            if (state_q == ST_FETCH && !ack_eff) begin
                drain_addr_d = pc_q;
            end
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (ack_eff) begin
                        pc_d = pc_q + PC_INC;
                        if (stall) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem_rdata;
                        end else begin
                            ifid_bus_d   = pack_ifid(pc_q + PC_INC, imem_rdata);
                            ifid_valid_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_bus_d   = pack_ifid(hold_pc_q + PC_INC, hold_instr_q);
                        ifid_valid_d = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Response to the stale address is simply dropped.
                end
                default: begin
                end
            endcase

            // Flush squashes the bus even under stall; FSM and PC carry on.
            if (flush) begin
                ifid_bus_d   = pack_ifid(32'h0, NOP_INSTR);
                ifid_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= NOP_INSTR;
            ifid_bus_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            ifid_bus_q   <= ifid_bus_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign ifid_bus   = ifid_bus_q;
    assign ifid_valid = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        fetch_accept;

    // A fetch is accepted when FETCH takes an ack that no redirect discards.
    assign fetch_accept = ack_eff && (state_q == ST_FETCH) && !redirect_valid;

    // Wrapping event counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (fetch_accept ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a per-cycle vector table
// (inputs, expected request/address, expected IF/ID result) with a
// scoreboard queue for the registered outputs, plus hand sequences for
// the performance counters and a wrap-around reset PC instance.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [63:0] ifid_bus;
    logic        ifid_valid;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    // Second instance with a reset PC at the top of the address space.
    logic        w_rst;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_zero;
    logic [31:0] w_zero32;
    logic [63:0] w_bus;
    logic        w_valid;
    logic [31:0] w_pfc;
    logic [31:0] w_psc;

    int checks   = 0;
    int failures = 0;

    if_fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_bus       (ifid_bus),
        .ifid_valid     (ifid_valid),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst            (w_rst),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata),
        .stall          (w_zero),
        .flush          (w_zero),
        .redirect_valid (w_zero),
        .redirect_pc    (w_zero32),
        .ifid_bus       (w_bus),
        .ifid_valid     (w_valid),
        .perf_fetch_cnt (w_pfc),
        .perf_stall_cnt (w_psc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [63:0] e_bus;
        logic        e_valid;
    } vec_t;

    typedef struct {
        int          idx;
        logic [63:0] bus;
        logic        valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                                input logic s, input logic f, input logic rv,
                                input logic [31:0] rp, input logic eq,
                                input logic [31:0] ea, input logic [63:0] eb,
                                input logic ev);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d; v.stall = s; v.flush = f;
        v.redir = rv; v.rpc = rp; v.e_req = eq; v.e_addr = ea;
        v.e_bus = eb; v.e_valid = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one row, check the combinational request side before the edge,
    // then compare the registered IF/ID result from the scoreboard after it.
    task automatic run_row(input int i, input vec_t r);
        exp_t e;
        @(negedge clk);
        rst            = r.rst;
        imem_ack       = r.ack;
        imem_rdata     = r.rdata;
        stall          = r.stall;
        flush          = r.flush;
        redirect_valid = r.redir;
        redirect_pc    = r.rpc;
        #1;
        check($sformatf("row%0d_req", i),  {63'b0, imem_req}, {63'b0, r.e_req});
        check($sformatf("row%0d_addr", i), {32'b0, imem_addr}, {32'b0, r.e_addr});
        e.idx = i; e.bus = r.e_bus; e.valid = r.e_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("row%0d_sb_empty", i), 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("row%0d_bus", e.idx),   ifid_bus, e.bus);
            check($sformatf("row%0d_valid", e.idx), {63'b0, ifid_valid}, {63'b0, e.valid});
        end
    endtask

    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        w_rst = 1'b1; w_ack = 1'b0; w_rdata = 32'h0; w_zero = 1'b0; w_zero32 = 32'h0;

        //               rst  ack rdata          stl  fl   rv   rpc         req  addr          bus                          valid
        vecs.push_back(mk(1'b1,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0000_0000,64'h0,                        1'b0)); // 0 reset
        vecs.push_back(mk(1'b0,1'b1,32'h2008_0005,1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0000,{32'h4,   32'h2008_0005},     1'b1)); // 1 first fetch
        vecs.push_back(mk(1'b0,1'b1,32'h1111_0001,1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0004,{32'h8,   32'h1111_0001},     1'b1)); // 2
        vecs.push_back(mk(1'b0,1'b1,32'h2222_0002,1'b1,1'b0,1'b0,32'h0,      1'b1,32'h0000_0008,{32'h8,   32'h1111_0001},     1'b1)); // 3 ack+stall
        vecs.push_back(mk(1'b0,1'b1,32'hBAD0_0000,1'b1,1'b0,1'b0,32'h0,      1'b0,32'h0000_000C,{32'h8,   32'h1111_0001},     1'b1)); // 4 hold
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,      1'b0,32'h0000_000C,{32'h8,   32'h1111_0001},     1'b1)); // 5 hold
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0000_000C,{32'hC,   32'h2222_0002},     1'b1)); // 6 release
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_000C,{32'hC,   32'h2222_0002},     1'b0)); // 7 no ack
        vecs.push_back(mk(1'b0,1'b1,32'h3333_0003,1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_000C,{32'h10,  32'h3333_0003},     1'b1)); // 8
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h100,    1'b1,32'h0000_0010,64'h0,                        1'b0)); // 9 redirect, pending
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0010,64'h0,                        1'b0)); // 10 drain
        vecs.push_back(mk(1'b0,1'b1,32'hDEAD_BEEF,1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0010,64'h0,                        1'b0)); // 11 drained ack
        vecs.push_back(mk(1'b0,1'b1,32'h4444_0004,1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0100,{32'h104, 32'h4444_0004},     1'b1)); // 12 target
        vecs.push_back(mk(1'b0,1'b1,32'h5555_0005,1'b1,1'b0,1'b0,32'h0,      1'b1,32'h0000_0104,{32'h104, 32'h4444_0004},     1'b1)); // 13 ack+stall
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0,      1'b0,32'h0000_0108,64'h0,                        1'b0)); // 14 flush+stall
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,      1'b0,32'h0000_0108,64'h0,                        1'b0)); // 15 stall
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0000_0108,{32'h108, 32'h5555_0005},     1'b1)); // 16 held delivered
        vecs.push_back(mk(1'b0,1'b1,32'hBAD0_0001,1'b0,1'b0,1'b1,32'h200,    1'b1,32'h0000_0108,64'h0,                        1'b0)); // 17 redirect+ack
        vecs.push_back(mk(1'b0,1'b1,32'h6666_0006,1'b0,1'b1,1'b0,32'h0,      1'b1,32'h0000_0200,64'h0,                        1'b0)); // 18 flush+ack
        vecs.push_back(mk(1'b0,1'b1,32'h7777_0007,1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0204,{32'h208, 32'h7777_0007},     1'b1)); // 19
        vecs.push_back(mk(1'b0,1'b1,32'h8888_0008,1'b1,1'b0,1'b0,32'h0,      1'b1,32'h0000_0208,{32'h208, 32'h7777_0007},     1'b1)); // 20 ack+stall
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,32'h300,    1'b0,32'h0000_020C,64'h0,                        1'b0)); // 21 redirect in hold
        vecs.push_back(mk(1'b0,1'b1,32'h9999_0009,1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0300,{32'h304, 32'h9999_0009},     1'b1)); // 22
        vecs.push_back(mk(1'b1,1'b1,32'hBAD0_0002,1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0000_0304,64'h0,                        1'b0)); // 23 reset mid-run
        vecs.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,      1'b1,32'h0000_0000,64'h0,                        1'b0)); // 24 restart

        repeat (2) @(posedge clk);

        for (int i = 0; i <= 22; i++) begin
            run_row(i, vecs[i]);
        end

        // 10 accepted acks (rows 1,2,3,8,12,13,18,19,20,22) and 8 stall cycles so far.
`ifdef IF_PERF_CNT_EN
        exp_fetch = 32'd10;
        exp_stall = 32'd8;
`else
        exp_fetch = 32'd0;
        exp_stall = 32'd0;
`endif
        check("perf_fetch_cnt", {32'b0, perf_fetch_cnt}, {32'b0, exp_fetch});
        check("perf_stall_cnt", {32'b0, perf_stall_cnt}, {32'b0, exp_stall});

        for (int i = 23; i < vecs.size(); i++) begin
            run_row(i, vecs[i]);
        end
        check("perf_fetch_cnt_after_rst", {32'b0, perf_fetch_cnt}, 64'd0);
        check("perf_stall_cnt_after_rst", {32'b0, perf_stall_cnt}, 64'd0);

        // PC wrap: reset PC 32'hFFFF_FFFC, one fetch returns PC+4 = 0.
        @(negedge clk);
        w_rst = 1'b0; w_ack = 1'b1; w_rdata = 32'h0000_0013;
        #1;
        check("wrap_req",  {63'b0, w_req}, 64'd1);
        check("wrap_addr", {32'b0, w_addr}, {32'b0, 32'hFFFF_FFFC});
        @(posedge clk);
        #1;
        check("wrap_bus",   w_bus, {32'h0000_0000, 32'h0000_0013});
        check("wrap_valid", {63'b0, w_valid}, 64'd1);
        @(negedge clk);
        w_ack = 1'b0;
        #1;
        check("wrap_next_addr", {32'b0, w_addr}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
